// File: rtl/ladder_seq_if.sv
// ladder_seq_if: start/scalar request, cswap handshake and ladder-step handshake of the ladder sequencer.
interface ladder_seq_if #(
    parameter int WID  = 256,
    parameter int IDXW = 8
);
    logic            start;
    logic [WID-1:0]  scalar;
    logic            swap_en;
    logic [WID-1:0]  swap_val;
    logic            swap_vld;
    logic            step_start;
    logic [IDXW-1:0] step_idx;
    logic            step_done;
    logic            busy;
    logic            done;
    modport master (
        input  start, scalar, swap_vld, step_done,
        output swap_en, swap_val, step_start, step_idx, busy, done
    );
    modport slave (
        output start, scalar, swap_vld, step_done,
        input  swap_en, swap_val, step_start, step_idx, busy, done
    );
endinterface

// File: rtl/ladder_seq.sv
// ladder_seq: Montgomery-ladder sequencer, MSB-first cswap + ladder step per bit, closing swap, done pulse.
// Define LADDER_CLAMP_EN to apply RFC 7748 clamping to the scalar on load.
module ladder_seq #(
    parameter int WID  = 256,
    parameter int IDXW = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    ladder_seq_if.master bus
);
    typedef enum logic [3:0] {IDLE, LOAD, SWAP, SWAPWT, STEP, STEPWT, FSWAP, FSWAPWT, DONE} state_t;
    state_t          r_state, w_next;
    logic [WID-1:0]  r_k, w_k_load;
    logic [IDXW-1:0] r_idx, w_idx_next;
    logic            r_prev, w_prev_next, r_swap, w_swap, w_kbit;
    assign w_kbit = r_k[r_idx];
`ifdef LADDER_CLAMP_EN
    always_comb begin
        w_k_load        = bus.scalar;
        w_k_load[2:0]   = 3'b000;
        w_k_load[WID-1] = 1'b0;
        w_k_load[WID-2] = 1'b1;
    end
`else
    assign w_k_load = bus.scalar;
`endif
    always_comb begin
        w_next      = r_state;
        w_idx_next  = r_idx;
        w_prev_next = r_prev;
        w_swap      = r_swap;
        case (r_state)
            IDLE:    if (bus.start) w_next = LOAD;
            LOAD: begin
                w_idx_next  = IDXW'(WID - 1);
                w_prev_next = 1'b0;
                w_next      = SWAP;
            end
            SWAP: begin
                w_swap      = r_prev ^ w_kbit;
                w_prev_next = w_kbit;
                w_next      = SWAPWT;
            end
            SWAPWT:  if (bus.swap_vld) w_next = STEP;
            STEP:    w_next = STEPWT;
            STEPWT: begin
                if (bus.step_done) begin
                    w_next     = (r_idx == '0) ? FSWAP : SWAP;
                    w_idx_next = (r_idx == '0) ? r_idx : r_idx - 1'b1;
                end
            end
            FSWAP: begin
                w_swap = r_prev;
                w_next = FSWAPWT;
            end
            FSWAPWT: if (bus.swap_vld) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_idx   <= '0;
            r_prev  <= 1'b0;
            r_swap  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_prev  <= w_prev_next;
            r_swap  <= w_swap;
            if (r_state == IDLE && bus.start) r_k <= w_k_load;
        end
    end
    // swap_val keeps the last issued swap bit until the next issue
    assign bus.swap_en    = (r_state == SWAP) || (r_state == FSWAP);
    assign bus.swap_val   = {{(WID-1){1'b0}}, w_swap};
    assign bus.step_start = (r_state == STEP);
    assign bus.step_idx   = r_idx;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
endmodule

// File: tb/tb_ladder_seq.sv
// tb_ladder_seq: random and directed scalars against a bit-difference swap model, with cswap and ladder-step responders.
module tb_ladder_seq;
    localparam int WID  = 8;
    localparam int IDXW = 3;
    logic clk, rst_n;
    logic inj_vld, spur, coin;
    int   lat = 2;
    int   total = 0, bad = 0;
    int   cyc = 0, n_done = 0, hold_bad = 0, upper_bad = 0;
    logic last_sw = 1'b0;
    logic [2:0] vsh;
    int   scnt;
    logic stp_d;
    bit   swq[$];
    int   idxq[$];

    ladder_seq_if #(.WID(WID), .IDXW(IDXW)) bus ();
    ladder_seq #(.WID(WID), .IDXW(IDXW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cswap answers 3 cycles after en; ladder step finishes lat cycles after start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsh   <= '0;
            scnt  <= 0;
            stp_d <= 1'b0;
        end else begin
            vsh   <= {vsh[1:0], bus.swap_en};
            stp_d <= bus.step_start;
            scnt  <= bus.step_start ? lat : (scnt > 0 ? scnt - 1 : 0);
        end
    end
    assign bus.swap_vld  = vsh[2] | (spur & stp_d) | inj_vld;
    assign bus.step_done = (scnt == 1) | (coin & bus.step_start);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_sw <= 1'b0;
        end else if (bus.swap_en) begin
            swq.push_back(bus.swap_val[0]);
            last_sw <= bus.swap_val[0];
        end else if (bus.swap_val[0] !== last_sw) begin
            hold_bad <= hold_bad + 1;
        end
        if (bus.swap_val[WID-1:1] != '0) upper_bad <= upper_bad + 1;
        if (bus.step_start) idxq.push_back(int'(bus.step_idx));
        if (bus.done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clamp(input logic [7:0] s);
`ifdef LADDER_CLAMP_EN
        return (s & 8'h78) | 8'h40;
`else
        return s;
`endif
    endfunction

    task automatic run(input logic [7:0] sc, input int l, input bit mid, input string tag);
        logic [7:0] k;
        bit e[$];
        int t0, b_sw, b_ix, b_dn, n;
        bit got, mid_done;
        k = clamp(sc);
        // swap bit i is the change between neighbouring scalar bits; final swap undoes the last bit
        for (int i = 7; i >= 0; i--) e.push_back((i == 7 ? 1'b0 : k[i+1]) ^ k[i]);
        e.push_back(k[0]);
        lat = l;
        b_sw = swq.size();
        b_ix = idxq.size();
        b_dn = n_done;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.scalar = sc;
        @(negedge clk);
        t0 = cyc;
        chk({tag, "_idle_busy"}, bus.busy, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.scalar = 8'($urandom);
        @(negedge clk);
        chk({tag, "_load_busy"}, bus.busy, 1);
        n = 0;
        got = 0;
        mid_done = 0;
        while (!got && n < 2000) begin
            if (mid && !mid_done && bus.step_start) begin
                @(posedge clk); #1;
                bus.start = 1'b1;
                bus.scalar = 8'h00;
                @(posedge clk); #1;
                bus.start = 1'b0;
                mid_done = 1;
            end
            @(negedge clk);
            n++;
            if (bus.done) got = 1;
        end
        #1;
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_latency"}, cyc - t0, 2 + 8 * (5 + l) + 4);
        chk({tag, "_n_swaps"}, swq.size() - b_sw, 9);
        for (int i = 0; i < 9 && b_sw + i < swq.size(); i++)
            chk($sformatf("%s_swap%0d", tag, i), swq[b_sw+i], e[i]);
        chk({tag, "_n_steps"}, idxq.size() - b_ix, 8);
        for (int i = 0; i < 8 && b_ix + i < idxq.size(); i++)
            chk($sformatf("%s_idx%0d", tag, i), idxq[b_ix+i], 7 - i);
        chk({tag, "_n_done"}, n_done - b_dn, 1);
        chk({tag, "_hold"}, hold_bad, 0);
        chk({tag, "_upper"}, upper_bad, 0);
    endtask

    initial begin
        int n, b;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.scalar = '0;
        inj_vld = 1'b0;
        spur = 1'b0;
        coin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_swap_en", bus.swap_en, 0);
        chk("rst_swap_val", bus.swap_val, 0);
        chk("rst_step_start", bus.step_start, 0);
        chk("rst_step_idx", bus.step_idx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        run(8'hB2, 2, 0, "b2");
        run(8'hFF, 1, 0, "ff");
        run(8'h5A, 2, 1, "mid");
        spur = 1'b1;
        coin = 1'b1;
        run(8'h3C, 3, 0, "quirk");
        spur = 1'b0;
        coin = 1'b0;
        repeat (6) run(8'($urandom), int'($urandom_range(1, 4)), 0, "rnd");
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.scalar = 8'hB2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.swap_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_swap_seen", bus.swap_en, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_swap_en", bus.swap_en, 0);
        chk("abort_swap_val", bus.swap_val, 0);
        chk("abort_step_start", bus.step_start, 0);
        chk("abort_step_idx", bus.step_idx, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b = swq.size();
        @(posedge clk); #1;
        inj_vld = 1'b1;
        @(posedge clk); #1;
        inj_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_vld_busy", bus.busy, 0);
        chk("late_vld_swaps", swq.size() - b, 0);
        run(8'hB2, 2, 0, "post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ladder_seq.md
# ladder_seq

Sequencer for the Montgomery-ladder scalar multiplier. It walks a latched scalar from MSB to LSB and, for each bit, drives one conditional swap through the `cswap` datapath (`en`/`vld` handshake). It then launches one external ladder step (add/double) and waits for it to finish. After the last bit it issues the closing swap and pulses `done`; it sits between the top-level scalar-mult control and the `cswap`/ladder-step datapaths.

## Interface
- `WID`, 256, scalar and swap-word width (X25519)
- `IDXW`, 8, bit-index width; requires 2^IDXW ≥ WID
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; samples `scalar`
- `scalar`  in  WID  scalar k, valid with `start`
- `swap_en`  out  1  one-cycle pulse to `cswap` `en`
- `swap_val`  out  WID  `cswap` `swap` word, value 0 or 1 (bit 0 only)
- `swap_vld`  in  1  `cswap` `vld`
- `step_start`  out  1  one-cycle pulse launching one ladder step
- `step_idx`  out  IDXW  current bit index i
- `step_done`  in  1  ladder step finished
- `busy`  out  1  high from LOAD through DONE
- `done`  out  1  one-cycle pulse; result swapped back and valid

## Operation
- States: IDLE, LOAD, SWAP, SWAPWT, STEP, STEPWT, FSWAP, FSWAPWT, DONE.
- IDLE: on `start`, latch `scalar` into `k_rg` and go to LOAD. A `start` outside IDLE is ignored and `k_rg` is unchanged.
- LOAD: set `idx = WID-1`, set `prev = 0`, go to SWAP.
- SWAP: drive `swap_en = 1` and `swap_val = prev ^ k_rg[idx]`, then set `prev <= k_rg[idx]` and go to SWAPWT.
- SWAPWT: wait for `swap_vld`, then go to STEP.
- STEP: drive `step_start = 1`, go to STEPWT.
- STEPWT: wait for `step_done`. On done:
  - if `idx == 0`, go to FSWAP;
  - otherwise decrement `idx` and go to SWAP.
- FSWAP: drive `swap_en = 1` and `swap_val = prev`, go to FSWAPWT.
- FSWAPWT: wait for `swap_vld`, go to DONE.
- DONE: pulse `done`, go to IDLE.
- `swap_val` is held stable from the SWAP/FSWAP cycle until the next swap issue. Bits above bit 0 are always zero.
- `swap_vld` or `step_done` arriving in any state other than its wait state is ignored and not remembered.
- `step_idx` mirrors `idx` throughout; it is 0 in IDLE.
- Exactly WID steps and WID+1 swaps are issued per scalar.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs 0: `swap_en`, `swap_val`, `step_start`, `step_idx`, `busy`, `done`. Internal `k_rg`, `idx` and `prev` are also 0.
- Reset mid-operation aborts immediately. No further pulses follow; the bench must also reset `cswap`.
- `start` sampled at cycle T: `busy` is 1 at T+1 (LOAD), and the first `swap_en` occurs at T+2.
- `cswap` returns `vld` 3 cycles after `en`. With `swap_en` at t:
  - `swap_vld` at t+3;
  - `step_start` at t+4;
  - with step latency L ≥ 1, `step_done` at t+4+L;
  - next `swap_en` at t+5+L.
- Final sequence: `swap_en` at f, `swap_vld` at f+3, `done` at f+4.
- `busy` falls in the cycle after `done`. A `start` in that IDLE cycle is accepted.
- `step_done` in the same cycle as `step_start` is ignored. It is accepted only from the following cycle.
- Total cycles from `start` to `done`: 2 + WID·(5+L) + 4.

## Configuration
- `LADDER_CLAMP_EN` defined: on load, `k_rg` receives `scalar` with these changes (RFC 7748 clamping):
  - bits [2:0] cleared;
  - bit WID-1 cleared;
  - bit WID-2 set.
- `LADDER_CLAMP_EN` undefined: `scalar` is latched unmodified.

## Test plan
1. WID=8, IDXW=3, no clamp, `scalar=8'b1011_0010`, L=2 → `swap_val` bit-0 sequence 1,1,1,0,1,0,1,1, then final 0. `step_idx` runs 7..0. `done` arrives 2+8·7+4=62 cycles after `start`.
2. Same scalar with `LADDER_CLAMP_EN` → `k_rg=8'b0111_0000`. Swaps are 0,1,0,0,1,0,0,0, then final 0.
3. `scalar=8'hFF`, no clamp → first swap 1, next seven swaps 0, final swap 1. Exactly 9 `swap_en` and 8 `step_start` pulses.
4. Second `start` during STEPWT with `scalar=8'h00` → ignored. The first run's swap sequence is unchanged and `done` is a single pulse.
5. Assert `rst` low during SWAPWT → all outputs 0 in the same cycle. A later `swap_vld` is ignored. A new `start` after release runs a clean sequence.
6. Spurious `swap_vld` in STEPWT, and `step_done` coincident with `step_start` → both ignored. The state holds until a legal `step_done`.
